mc_ctrl_unit: RTL
=================

MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 Parameter ILLEGAL_HALT, default 0: 0 = illegal instruction returns to FETCH; 1 = illegal instruction parks in HALT until reset.
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Clrn  in  1  reset, asynchronous, active-low.
REQ-004 Op  in  6  opcode from instruction register.
REQ-005 Func  in  6  R-type function field.
REQ-006 Z  in  1  ALU zero flag.
REQ-007 Aluc  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
REQ-008 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA  out  1 each  datapath strobes/selects.
REQ-009 ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 zero-ext imm.
REQ-010 PCSource  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-011 PCEn  out  1  PCWrite | (PCWriteCond & Z).
REQ-012 InstrDone  out  1  one-cycle pulse in final state of each instruction.
REQ-013 Illegal  out  1  one-cycle pulse in DECODE on unsupported Op/Func.
REQ-014 State  out  4  current state encoding, debug.

Function
REQ-015 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, HALT.
REQ-016 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, Aluc=00, PCSource=00, PCWrite=1; next DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=10, Aluc=00 (branch target); Op and Func latched internally; next by Op: 100011/101011 -> MEM_ADDR, 000000 -> EXEC_R, 001000/001100/001101 -> EXEC_I, 000100 -> BRANCH, 000010 -> JUMP, else illegal.
REQ-018 Supported R-type Func: 100000 add, 100010 sub, 100100 and, 100101 or; any other Func with Op=000000 is illegal.
REQ-019 Illegal: Illegal=1 in DECODE, no write strobe asserted; next FETCH if ILLEGAL_HALT=0, else HALT.
REQ-020 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, Aluc=00; next MEM_RD (lw) or MEM_WR (sw) from latched Op.
REQ-021 MEM_RD: MemRead=1, IorD=1; next MEM_WB. MEM_WB: RegWrite=1, MemToReg=1, RegDst=0, InstrDone=1; next FETCH.
REQ-022 MEM_WR: MemWrite=1, IorD=1, InstrDone=1; next FETCH.
REQ-023 EXEC_R: ALUSrcA=1, ALUSrcB=00, Aluc from latched Func per REQ-018; next WB_R. WB_R: RegWrite=1, RegDst=1, MemToReg=0, InstrDone=1; next FETCH.
REQ-024 EXEC_I: ALUSrcA=1; addi ALUSrcB=10 Aluc=00; andi ALUSrcB=11 Aluc=10; ori ALUSrcB=11 Aluc=11; next WB_I. WB_I: RegWrite=1, RegDst=0, MemToReg=0, InstrDone=1; next FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, Aluc=01, PCWriteCond=1, PCSource=01, InstrDone=1; next FETCH.
REQ-026 JUMP: PCWrite=1, PCSource=10, InstrDone=1; next FETCH.
REQ-027 HALT: all strobes 0; remains until Clrn low.
REQ-028 Outputs Moore: function of state and latched Op/Func only, except PCEn (combinational with Z).
REQ-029 Latency in cycles: lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3, illegal 2.
REQ-030 Op/Func changes outside DECODE have no effect.
REQ-031 Strobes not named for a state are 0 in that state.

Reset
REQ-032 Clrn low: state forced to FETCH immediately, latched Op/Func cleared to 0, regardless of current state (including HALT, mid-instruction).
REQ-033 While Clrn low all write strobes (PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite) and InstrDone, Illegal are 0; first FETCH cycle begins at first rising Clk after Clrn high.

Structure
REQ-034 State encodings, opcode/func constants and Aluc codes live in a shared package mc_ctrl_pkg, reused by the ALU testbench.
REQ-035 One sub-module, alu_op_decode: combinational latched Op/Func -> Aluc, ALUSrcB, legality flag.

Verification
REQ-036 Release reset, Op=100011 -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; RegWrite=1 and InstrDone=1 only in cycle 5.
REQ-037 Op=000000 Func=100010 -> Aluc=01 in EXEC_R, RegDst=1 in WB_R, 4 cycles.
REQ-038 Op=000100 with Z=1 then Z=0 -> PCEn=1 / PCEn=0 in BRANCH, 3 cycles each.
REQ-039 Op=001101 -> ALUSrcB=11, Aluc=11 in EXEC_I; Op=001100 -> Aluc=10.
REQ-040 Op=111111 with ILLEGAL_HALT=0 -> Illegal pulse, FETCH next; with ILLEGAL_HALT=1 -> HALT held 20 cycles, exits only on Clrn low.
REQ-041 Clrn asserted mid MEM_WR -> MemWrite drops without waiting for Clk; State=FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle control unit: state encodings,
// opcode/function fields, ALU operation codes and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_WB_I     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;

  localparam logic [1:0] ALUC_ADD = 2'b00;
  localparam logic [1:0] ALUC_SUB = 2'b01;
  localparam logic [1:0] ALUC_AND = 2'b10;
  localparam logic [1:0] ALUC_OR  = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_ZEXT  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/function decoder: picks the ALU operation and
// second-operand source for execute states and flags unsupported encodings.
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [1:0] aluc,
  output logic [1:0] alu_src_b,
  output logic       legal
);

  always_comb begin
    aluc      = ALUC_ADD;
    alu_src_b = SRCB_SEXT;
    legal     = 1'b0;
    case (op)
      OP_RTYPE: begin
        alu_src_b = SRCB_REG;
        legal     = 1'b1;
        case (func)
          FUNC_ADD: aluc = ALUC_ADD;
          FUNC_SUB: aluc = ALUC_SUB;
          FUNC_AND: aluc = ALUC_AND;
          FUNC_OR:  aluc = ALUC_OR;
          default:  legal = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
      OP_ANDI: begin
        alu_src_b = SRCB_ZEXT;
        aluc      = ALUC_AND;
        legal     = 1'b1;
      end
      OP_ORI: begin
        alu_src_b = SRCB_ZEXT;
        aluc      = ALUC_OR;
        legal     = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Moore-style control FSM for a multicycle MIPS-like datapath, sequencing
// lw/sw/R-type/I-type/beq/j through their fetch-decode-execute states.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       Clk,
  input  logic       Clrn,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       Z,
  output logic [1:0] Aluc,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCEn,
  output logic       InstrDone,
  output logic       Illegal,
  output logic [3:0] State
);

  state_t     state, state_next;
  logic [5:0] op_q, func_q;
  logic       running;
  logic [5:0] dec_op, dec_func;
  logic [1:0] dec_aluc, dec_src_b;
  logic       dec_legal;

  // Instruction fields are only live in DECODE; afterwards use the copy.
  assign dec_op   = (state == ST_DECODE) ? Op   : op_q;
  assign dec_func = (state == ST_DECODE) ? Func : func_q;

  alu_op_decode u_dec (
    .op        (dec_op),
    .func      (dec_func),
    .aluc      (dec_aluc),
    .alu_src_b (dec_src_b),
    .legal     (dec_legal)
  );

  // running holds the first FETCH back until the first edge after reset release.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state   <= ST_FETCH;
      op_q    <= '0;
      func_q  <= '0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= 1'b1;
      if (state == ST_DECODE) begin
        op_q   <= Op;
        func_q <= Func;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:    state_next = running ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (!dec_legal)
          state_next = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
        else begin
          case (Op)
            OP_LW, OP_SW:             state_next = ST_MEM_ADDR;
            OP_RTYPE:                 state_next = ST_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI: state_next = ST_EXEC_I;
            OP_BEQ:                   state_next = ST_BRANCH;
            OP_J:                     state_next = ST_JUMP;
            default:                  state_next = ST_FETCH;
          endcase
        end
      end
      ST_MEM_ADDR: state_next = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   state_next = ST_MEM_WB;
      ST_EXEC_R:   state_next = ST_WB_R;
      ST_EXEC_I:   state_next = ST_WB_I;
      ST_HALT:     state_next = ST_HALT;
      default:     state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    Aluc        = ALUC_ADD;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    InstrDone   = 1'b0;
    Illegal     = 1'b0;
    if (running) begin
      case (state)
        ST_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        ST_DECODE: begin
          ALUSrcB = SRCB_SEXT;
          Illegal = !dec_legal;
        end
        ST_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_SEXT;
        end
        ST_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEM_WB: begin
          RegWrite  = 1'b1;
          MemToReg  = 1'b1;
          InstrDone = 1'b1;
        end
        ST_MEM_WR: begin
          MemWrite  = 1'b1;
          IorD      = 1'b1;
          InstrDone = 1'b1;
        end
        ST_EXEC_R, ST_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = dec_src_b;
          Aluc    = dec_aluc;
        end
        ST_WB_R: begin
          RegWrite  = 1'b1;
          RegDst    = 1'b1;
          InstrDone = 1'b1;
        end
        ST_WB_I: begin
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA     = 1'b1;
          Aluc        = ALUC_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          InstrDone   = 1'b1;
        end
        ST_JUMP: begin
          PCWrite   = 1'b1;
          PCSource  = PCSRC_JUMP;
          InstrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign PCEn  = PCWrite | (PCWriteCond & Z);
  assign State = state;

endmodule
